i2c_byte_ctrl: RTL and testbench



---
 rtl/i2c_byte_ctrl.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_i2c_byte_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_ctrl.sv
// i2c_byte_ctrl: byte-level I2C master sequencer.
// Turns host byte commands into MSB-first bit commands for the bit FSM.
module i2c_byte_ctrl #(
  parameter int unsigned      WDT_W   = 16,
  parameter logic [WDT_W-1:0] WDT_MAX = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       start,
  input  logic       stop,
  input  logic       write,
  input  logic       read,
  input  logic       ack_in,
  input  logic [7:0] din,
  input  logic       bit_cmd_ack,
  input  logic       bit_dout,
  input  logic       bit_ack,
  input  logic       bit_al,
  output logic [3:0] bit_cmd,
  output logic       bit_din,
  output logic       cmd_ack,
  output logic [7:0] dout,
  output logic       ack_out,
  output logic       arb_lost,
  output logic       timeout
);

  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  localparam logic [WDT_W-1:0] WDT_ONE =
    {{(WDT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WRITE,
    S_READ,
    S_ACK,
    S_ACK_SMP,
    S_STOP,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [7:0]       r_sr;
  logic [7:0]       w_sr;
  logic [2:0]       r_cnt;
  logic [2:0]       w_cnt;
  logic [WDT_W-1:0] r_wdt;
  logic [WDT_W-1:0] w_wdt;
  logic [WDT_W-1:0] w_wdt_inc;
  logic             r_ack_prev;
  logic             w_acc;
  logic             w_busy;
  logic             w_expire;
  logic             w_latch;
  logic             w_al_set;
  logic             w_to_set;
  logic             w_ack_nxt;
  logic             w_rd_eff;
  logic             r_f_wr;
  logic             r_f_rd;
  logic             r_f_stop;
  logic             r_f_ai;
  logic [3:0]       r_bit_cmd;
  logic             r_bit_din;
  logic             r_cmd_ack;
  logic [7:0]       r_dout;
  logic             r_ack_out;
  logic             r_arb_lost;
  logic             r_timeout;
  logic [3:0]       w_cmd;
  logic             w_din;

  // Data phase that follows START (or IDLE without START).
  function automatic state_t f_data(
    input logic i_wr,
    input logic i_rd,
    input logic i_sp
  );
    if (i_wr)
      return S_WRITE;
    else if (i_rd)
      return S_READ;
    else if (i_sp)
      return S_STOP;
    else
      return S_DONE;
  endfunction

  assign w_acc     = bit_cmd_ack & ~r_ack_prev;
  assign w_wdt_inc = r_wdt + WDT_ONE;
  assign w_busy    = (r_state == S_START) ||
                     (r_state == S_WRITE) ||
                     (r_state == S_READ)  ||
                     (r_state == S_ACK)   ||
                     (r_state == S_STOP);
  assign w_expire  = w_busy &&
                     (WDT_MAX != '0) &&
                     (w_wdt_inc == WDT_MAX);
  assign w_rd_eff  = w_latch ? (read & ~write)
                             : r_f_rd;

  // Next-state, shifter and status-event decode.
  always_comb begin
    w_nxt     = r_state;
    w_sr      = r_sr;
    w_cnt     = r_cnt;
    w_latch   = 1'b0;
    w_ack_nxt = r_ack_out;
    w_al_set  = 1'b0;
    w_to_set  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (go) begin
          w_latch = 1'b1;
          w_sr    = din;
          w_cnt   = 3'd7;
          if (start)
            w_nxt = S_START;
          else
            w_nxt = f_data(write, read, stop);
        end
      end
      S_START: begin
        if (w_acc)
          w_nxt = f_data(r_f_wr, r_f_rd, r_f_stop);
      end
      S_WRITE: begin
        if (w_acc) begin
          w_sr  = {r_sr[6:0], 1'b0};
          w_cnt = r_cnt - 3'd1;
          if (r_cnt == 3'd0)
            w_nxt = S_ACK;
        end
      end
      S_READ: begin
        if (w_acc) begin
          w_sr  = {r_sr[6:0], bit_dout};
          w_cnt = r_cnt - 3'd1;
          if (r_cnt == 3'd0)
            w_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (w_acc)
          w_nxt = S_ACK_SMP;
      end
      S_ACK_SMP: begin
        if (r_f_wr)
          w_ack_nxt = bit_ack;
        w_nxt = r_f_stop ? S_STOP : S_DONE;
      end
      S_STOP: begin
        if (w_acc)
          w_nxt = S_DONE;
      end
      S_DONE: begin
        w_nxt = S_IDLE;
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
    // A stalled bit beats a late acceptance.
    if (w_expire && !bit_al) begin
      w_to_set = 1'b1;
      w_nxt    = S_DONE;
      w_sr     = r_sr;
      w_cnt    = r_cnt;
    end
    // Lost arbitration drops the rest of the byte.
    if (bit_al && (r_state != S_IDLE)) begin
      w_al_set = 1'b1;
      if (r_state != S_DONE) begin
        w_nxt     = S_DONE;
        w_sr      = r_sr;
        w_cnt     = r_cnt;
        w_ack_nxt = r_ack_out;
      end
    end
  end

  // Per-bit watchdog: restarts on any state change or acceptance.
  always_comb begin
    w_wdt = '0;
    if (w_busy && (w_nxt == r_state) && !w_acc)
      w_wdt = w_wdt_inc;
  end

  // Bit command and bit data for the state being entered.
  always_comb begin
    w_cmd = CMD_NOP;
    w_din = 1'b1;
    unique case (w_nxt)
      S_START: w_cmd = CMD_START;
      S_WRITE: begin
        w_cmd = CMD_WRITE;
        w_din = w_sr[7];
      end
      S_READ:  w_cmd = CMD_READ;
      S_ACK:   w_din = r_f_rd ? r_f_ai : 1'b1;
      S_STOP:  w_cmd = CMD_STOP;
      default: w_cmd = CMD_NOP;
    endcase
  end

  // Sequencer state, shifter, counter and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sr       <= 8'h00;
      r_cnt      <= 3'd7;
      r_wdt      <= '0;
      r_ack_prev <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_sr       <= w_sr;
      r_cnt      <= w_cnt;
      r_wdt      <= w_wdt;
      r_ack_prev <= bit_cmd_ack;
    end
  end

  // Command flags captured when a host request is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f_wr   <= 1'b0;
      r_f_rd   <= 1'b0;
      r_f_stop <= 1'b0;
      r_f_ai   <= 1'b0;
    end else if (w_latch) begin
      r_f_wr   <= write;
      r_f_rd   <= read & ~write;
      r_f_stop <= stop;
      r_f_ai   <= ack_in;
    end
  end

  // Registered bit-FSM outputs and host done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cmd <= CMD_NOP;
      r_bit_din <= 1'b1;
      r_cmd_ack <= 1'b0;
    end else begin
      r_bit_cmd <= w_cmd;
      r_bit_din <= w_din;
      r_cmd_ack <= (w_nxt == S_DONE);
    end
  end

  // Host-visible read data, ACK and sticky status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout     <= 8'h00;
      r_ack_out  <= 1'b0;
      r_arb_lost <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_ack_out <= w_ack_nxt;
      if ((w_nxt == S_DONE) &&
          (r_state != S_DONE) &&
          w_rd_eff)
        r_dout <= w_sr;
      if (w_latch)
        r_arb_lost <= 1'b0;
      else if (w_al_set)
        r_arb_lost <= 1'b1;
      if (w_latch)
        r_timeout <= 1'b0;
      else if (w_to_set)
        r_timeout <= 1'b1;
    end
  end

  assign bit_cmd  = r_bit_cmd;
  assign bit_din  = r_bit_din;
  assign cmd_ack  = r_cmd_ack;
  assign dout     = r_dout;
  assign ack_out  = r_ack_out;
  assign arb_lost = r_arb_lost;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// tb_i2c_byte_ctrl: table vectors through a scoreboarded bit-FSM
// responder, plus abort, watchdog and reset sequences.
`timescale 1ns/1ps
module tb_i2c_byte_ctrl;

  localparam logic [3:0] NOP = 4'b0000;
  localparam logic [3:0] STA = 4'b0001;
  localparam logic [3:0] STO = 4'b0010;
  localparam logic [3:0] WRC = 4'b0100;
  localparam logic [3:0] RDC = 4'b1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       go, start, stop, write, read, ack_in;
  logic [7:0] din;
  logic       bit_cmd_ack, bit_dout, bit_ack, bit_al;
  logic [3:0] bit_cmd;
  logic       bit_din, cmd_ack, ack_out, arb_lost, timeout;
  logic [7:0] dout;

  always #5 clk = ~clk;

  i2c_byte_ctrl #(
    .WDT_W   (16),
    .WDT_MAX (16'd16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .start       (start),
    .stop        (stop),
    .write       (write),
    .read        (read),
    .ack_in      (ack_in),
    .din         (din),
    .bit_cmd_ack (bit_cmd_ack),
    .bit_dout    (bit_dout),
    .bit_ack     (bit_ack),
    .bit_al      (bit_al),
    .bit_cmd     (bit_cmd),
    .bit_din     (bit_din),
    .cmd_ack     (cmd_ack),
    .dout        (dout),
    .ack_out     (ack_out),
    .arb_lost    (arb_lost),
    .timeout     (timeout)
  );

  typedef struct {
    logic       st, sp, wr, rd, ai;
    logic [7:0] din;
    logic [7:0] rbyte;
    logic       sack;
    int         hold;
    logic [7:0] exp_dout;
    logic       exp_ack;
  } vec_t;

  typedef struct {
    logic [3:0] cmd;
    logic       chk_din;
    logic       din;
  } exp_bit_t;

  typedef struct {
    logic [7:0] dout;
    logic       ack;
  } exp_res_t;

  exp_bit_t q_bit[$];
  exp_res_t q_res[$];
  vec_t     vt[11];
  int       n_chk = 0;
  int       n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic st, sp, wr, rd, ai,
    input logic [7:0] d, rb,
    input logic sack,
    input int hold,
    input logic [7:0] ed,
    input logic ea);
    vec_t v;
    v.st = st; v.sp = sp; v.wr = wr;
    v.rd = rd; v.ai = ai; v.din = d;
    v.rbyte = rb; v.sack = sack;
    v.hold = hold; v.exp_dout = ed;
    v.exp_ack = ea;
    return v;
  endfunction

  function automatic exp_bit_t mb(
    input logic [3:0] c,
    input logic cd,
    input logic d);
    exp_bit_t e;
    e.cmd = c; e.chk_din = cd; e.din = d;
    return e;
  endfunction

  // Expected bit stream and result for one byte command.
  task automatic push_model(input vec_t v);
    exp_res_t r;
    if (v.st)
      q_bit.push_back(mb(STA, 1'b0, 1'b1));
    if (v.wr) begin
      for (int i = 0; i < 8; i++)
        q_bit.push_back(mb(WRC, 1'b1, v.din[7-i]));
      q_bit.push_back(mb(NOP, 1'b1, 1'b1));
    end else if (v.rd) begin
      for (int i = 0; i < 8; i++)
        q_bit.push_back(mb(RDC, 1'b0, 1'b1));
      q_bit.push_back(mb(NOP, 1'b1, v.ai));
    end
    if (v.sp)
      q_bit.push_back(mb(STO, 1'b0, 1'b1));
    r.dout = v.exp_dout;
    r.ack  = v.exp_ack;
    q_res.push_back(r);
  endtask

  task automatic run_vec(input int k);
    vec_t     v;
    exp_bit_t e;
    exp_res_t r;
    int       left;
    int       rd_i;
    bit       done;
    v = vt[k];
    push_model(v);
    @(negedge clk);
    start  = v.st;
    stop   = v.sp;
    write  = v.wr;
    read   = v.rd;
    ack_in = v.ai;
    din    = v.din;
    bit_ack = v.sack;
    go     = 1'b1;
    left = 0;
    rd_i = 0;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (cmd_ack) begin
        go = 1'b0;
        bit_cmd_ack = 1'b0;
        done = 1'b1;
        r = q_res.pop_front();
        chk($sformatf("v%0d dout", k), dout, r.dout);
        chk($sformatf("v%0d ack_out", k), ack_out, r.ack);
        chk($sformatf("v%0d arb_lost", k), arb_lost, 0);
        chk($sformatf("v%0d timeout", k), timeout, 0);
        chk($sformatf("v%0d done cmd", k), bit_cmd, NOP);
        chk($sformatf("v%0d bits left", k),
            q_bit.size(), 0);
        @(negedge clk);
        chk($sformatf("v%0d ack pulse", k), cmd_ack, 0);
      end else if (left > 0) begin
        left--;
        if (left == 0)
          bit_cmd_ack = 1'b0;
      end else if (q_bit.size() != 0) begin
        e = q_bit.pop_front();
        chk($sformatf("v%0d cmd", k), bit_cmd, e.cmd);
        if (e.chk_din)
          chk($sformatf("v%0d din", k), bit_din, e.din);
        if (e.cmd == RDC && rd_i < 8) begin
          bit_dout = v.rbyte[7-rd_i];
          rd_i++;
        end
        bit_cmd_ack = 1'b1;
        left = v.hold;
      end
    end
    if (!done) begin
      n_chk++;
      n_err++;
      $display("FAIL v%0d no cmd_ack: got 0 expected 1", k);
      q_bit.delete();
      q_res.delete();
      go = 1'b0;
      bit_cmd_ack = 1'b0;
    end
  endtask

  // Check the current bit command, accept it, then one low cycle.
  task automatic one_bit(input string nm,
                         input logic [3:0] c,
                         input logic cd,
                         input logic d,
                         input logic sda);
    chk({nm, " cmd"}, bit_cmd, c);
    if (cd)
      chk({nm, " din"}, bit_din, d);
    bit_dout = sda;
    bit_cmd_ack = 1'b1;
    @(negedge clk);
    bit_cmd_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " bit_cmd"}, bit_cmd, NOP);
    chk({nm, " bit_din"}, bit_din, 1);
    chk({nm, " cmd_ack"}, cmd_ack, 0);
    chk({nm, " dout"}, dout, 0);
    chk({nm, " ack_out"}, ack_out, 0);
    chk({nm, " arb_lost"}, arb_lost, 0);
    chk({nm, " timeout"}, timeout, 0);
  endtask

  logic [7:0] bt;
  int         n;

  initial begin
    vt[0]  = mk(1,0,1,0,0, 8'hA5, 8'h00, 1, 1, 8'h00, 1);
    vt[1]  = mk(0,1,0,1,1, 8'h00, 8'h3C, 0, 1, 8'h3C, 1);
    vt[2]  = mk(0,1,1,0,0, 8'h3C, 8'h00, 0, 3, 8'h3C, 0);
    vt[3]  = mk(1,0,0,1,0, 8'h00, 8'h96, 1, 2, 8'h96, 0);
    vt[4]  = mk(0,1,0,0,0, 8'h00, 8'h00, 1, 1, 8'h96, 0);
    vt[5]  = mk(0,0,0,0,0, 8'hFF, 8'h00, 1, 1, 8'h96, 0);
    vt[6]  = mk(0,0,1,1,0, 8'h81, 8'hFF, 1, 1, 8'h96, 1);
    vt[7]  = mk(1,1,0,0,0, 8'h00, 8'h00, 0, 1, 8'h96, 1);
    vt[8]  = mk(0,0,0,1,1, 8'h00, 8'hC3, 0, 1, 8'hC3, 1);
    vt[9]  = mk(1,0,1,0,0, 8'h0F, 8'h00, 0, 1, 8'hC3, 0);
    vt[10] = mk(0,0,0,1,0, 8'h00, 8'h55, 0, 1, 8'h55, 0);

    rst = 1'b1;
    go = 0; start = 0; stop = 0; write = 0;
    read = 0; ack_in = 0; din = 8'h00;
    bit_cmd_ack = 0; bit_dout = 0;
    bit_ack = 0; bit_al = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    for (int k = 0; k < 8; k++)
      run_vec(k);

    // Arbitration lost after the third WRITE acceptance.
    @(negedge clk);
    start = 1; write = 1; read = 0; stop = 0;
    din = 8'h5A; go = 1;
    @(negedge clk);
    one_bit("al start", STA, 1'b0, 1'b1, 1'b0);
    bt = 8'h5A;
    for (int i = 0; i < 3; i++)
      one_bit("al write", WRC, 1'b1, bt[7-i], 1'b0);
    bit_al = 1'b1;
    @(negedge clk);
    bit_al = 1'b0;
    go = 1'b0;
    chk("al cmd_ack", cmd_ack, 1);
    chk("al bit_cmd", bit_cmd, NOP);
    chk("al arb_lost", arb_lost, 1);
    chk("al timeout", timeout, 0);
    @(negedge clk);
    chk("al pulse", cmd_ack, 0);
    chk("al sticky", arb_lost, 1);
    run_vec(8);

    // START never accepted: watchdog aborts.
    @(negedge clk);
    start = 1; write = 1; read = 0; stop = 0;
    din = 8'h0F; go = 1;
    @(negedge clk);
    chk("wdt start", bit_cmd, STA);
    n = 0;
    while (!cmd_ack && n < 100) begin
      @(negedge clk);
      n++;
    end
    go = 1'b0;
    chk("wdt cycles", n, 16);
    chk("wdt timeout", timeout, 1);
    chk("wdt bit_cmd", bit_cmd, NOP);
    chk("wdt arb_lost", arb_lost, 0);
    @(negedge clk);
    chk("wdt sticky", timeout, 1);
    chk("wdt pulse", cmd_ack, 0);
    run_vec(9);

    // Asynchronous reset in the middle of a read.
    @(negedge clk);
    start = 0; write = 0; read = 1; stop = 0;
    ack_in = 0; go = 1;
    @(negedge clk);
    bt = 8'hB0;
    for (int i = 0; i < 4; i++)
      one_bit("rst read", RDC, 1'b0, 1'b1, bt[7-i]);
    chk("rst pre cmd", bit_cmd, RDC);
    chk("rst pre dout", dout, 8'hC3);
    #2 rst = 1'b1;
    #1 chk_reset_vals("midrst");
    go = 1'b0;
    bit_cmd_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_vec(10);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
